// File: rtl/serial_addsub_32bit_if.sv
// Request/result bundle for the serial 32-bit adder/subtractor.
// The master side issues start/op/operands; the slave side returns status and result.
interface serial_addsub_32bit_if;
    logic        start;
    logic        op;
    logic [31:0] input1;
    logic [31:0] input2;
    logic        busy;
    logic        done;
    logic [31:0] adder_output;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic        negative;

    modport master (
        output start, op, input1, input2,
        input  busy, done, adder_output, carry, overflow, zero, negative
    );

    modport slave (
        input  start, op, input1, input2,
        output busy, done, adder_output, carry, overflow, zero, negative
    );
endinterface

// File: rtl/serial_addsub_32bit.sv
// Slice-serial 32-bit add/subtract: SLICE_W bits per cycle, LSB slice first,
// with the carry chained through a register between slices.
module serial_addsub_32bit #(
    parameter int SLICE_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_addsub_32bit_if.slave bus
);
    localparam int N     = 32 / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [31:0] SLICE_MASK = 32'((64'd1 << SLICE_W) - 64'd1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [31:0]        sum_q;
    logic               cin_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               carry_q;
    logic               ovf_q;
    logic               zero_q;
    logic               neg_q;

    logic [4:0]         shamt;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W:0]   slice_sum;
    logic [31:0]        merged;
    logic               last;

    // The current slice is selected by shifting; merged keeps the other bits of the partial sum.
    always_comb begin
        shamt     = 5'(32'(cnt_q) * 32'(SLICE_W));
        slice_a   = SLICE_W'(a_q >> shamt);
        slice_b   = SLICE_W'(b_q >> shamt);
        slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + (SLICE_W+1)'(cin_q);
        merged    = (sum_q & ~(SLICE_MASK << shamt))
                  | (32'(slice_sum[SLICE_W-1:0]) << shamt);
        last      = (cnt_q == CNT_W'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cin_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            neg_q   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q    <= bus.input1;
                        b_q    <= bus.op ? ~bus.input2 : bus.input2;
                        cin_q  <= bus.op;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    sum_q <= merged;
                    cin_q <= slice_sum[SLICE_W];
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        state   <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        carry_q <= slice_sum[SLICE_W];
                        ovf_q   <= (a_q[31] == b_q[31]) && (merged[31] != a_q[31]);
                        zero_q  <= (merged == '0);
                        neg_q   <= merged[31];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.adder_output = sum_q;
    assign bus.carry        = carry_q;
    assign bus.overflow     = ovf_q;
    assign bus.zero         = zero_q;
    assign bus.negative     = neg_q;
endmodule

// File: tb/tb_serial_addsub_32bit.sv
// Bench for serial_addsub_32bit: directed vector table plus random runs on
// SLICE_W = 8, 1 and 32 instances, checked through per-instance scoreboards.
module tb_serial_addsub_32bit;
    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        wide_en = 1'b0;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    exp_t q8[$];
    exp_t q1[$];
    exp_t q32[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_addsub_32bit_if if8();
    serial_addsub_32bit_if if1();
    serial_addsub_32bit_if if32();

    assign if8.start   = start;
    assign if8.op      = op;
    assign if8.input1  = in_a;
    assign if8.input2  = in_b;
    assign if1.start   = start && wide_en;
    assign if1.op      = op;
    assign if1.input1  = in_a;
    assign if1.input2  = in_b;
    assign if32.start  = start && wide_en;
    assign if32.op     = op;
    assign if32.input1 = in_a;
    assign if32.input2 = in_b;

    serial_addsub_32bit #(.SLICE_W(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_addsub_32bit #(.SLICE_W(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_addsub_32bit #(.SLICE_W(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sr;
        logic [32:0] t;
        t = {1'b0, a} + {1'b0, b};
        if (o) begin
            e.r = a - b;
            e.c = (a >= b);
            sr  = longint'($signed(a)) - longint'($signed(b));
        end else begin
            e.r = t[31:0];
            e.c = t[32];
            sr  = longint'($signed(a)) + longint'($signed(b));
        end
        e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.z   = (e.r == 32'h0);
        e.n   = e.r[31];
        e.cyc = 0;
        return e;
    endfunction

    // Result-side scoreboard check shared by all instances.
    task automatic check_done(input string nm, input exp_t e, input logic [31:0] r,
                              input logic c, input logic v, input logic z, input logic n,
                              input logic b);
        cmp({nm, " result"},   r, e.r);
        cmp({nm, " carry"},    32'(c), 32'(e.c));
        cmp({nm, " overflow"}, 32'(v), 32'(e.v));
        cmp({nm, " zero"},     32'(z), 32'(e.z));
        cmp({nm, " negative"}, 32'(n), 32'(e.n));
        cmp({nm, " latency"},  cyc, e.cyc);
        cmp({nm, " busy_at_done"}, 32'(b), 32'h0);
    endtask

    always @(negedge clk) begin
        if (if8.done) begin
            if (q8.size() == 0) cmp("w8 unexpected_done", 32'h1, 32'h0);
            else check_done("w8", q8.pop_front(), if8.adder_output, if8.carry,
                            if8.overflow, if8.zero, if8.negative, if8.busy);
        end
    end

    always @(negedge clk) begin
        if (if1.done) begin
            if (q1.size() == 0) cmp("w1 unexpected_done", 32'h1, 32'h0);
            else check_done("w1", q1.pop_front(), if1.adder_output, if1.carry,
                            if1.overflow, if1.zero, if1.negative, if1.busy);
        end
    end

    always @(negedge clk) begin
        if (if32.done) begin
            if (q32.size() == 0) cmp("w32 unexpected_done", 32'h1, 32'h0);
            else check_done("w32", q32.pop_front(), if32.adder_output, if32.carry,
                            if32.overflow, if32.zero, if32.negative, if32.busy);
        end
    end

    // Called between a falling and the next rising edge; leaves after the following falling edge.
    task automatic drive(input logic o, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input logic push);
        exp_t e1;
        exp_t e32;
        start = 1'b1;
        op    = o;
        in_a  = a;
        in_b  = b;
        if (push) begin
            e.cyc = cyc + 4 + 1;
            q8.push_back(e);
            if (wide_en) begin
                e1      = model(o, a, b);
                e1.cyc  = cyc + 32 + 1;
                e32     = e1;
                e32.cyc = cyc + 1 + 1;
                q1.push_back(e1);
                q32.push_back(e32);
            end
        end
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_empty(input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (q8.size() == 0 && q1.size() == 0 && q32.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            cmp("done_timeout", 32'(q8.size() + q1.size() + q32.size()), 32'h0);
            q8.delete();
            q1.delete();
            q32.delete();
        end
    endtask

    function automatic exp_t from_vec(input vec_t v);
        exp_t e;
        e.r = v.r; e.c = v.c; e.v = v.v; e.z = v.z; e.n = v.n; e.cyc = 0;
        return e;
    endfunction

    initial begin
        vec_t vecs[9];
        exp_t e;
        bit   got;
        vecs[0] = '{1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 32'h0000_000A, 32'h0000_000A, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        #1;
        cmp("reset busy",     32'(if8.busy), 32'h0);
        cmp("reset done",     32'(if8.done), 32'h0);
        cmp("reset result",   if8.adder_output, 32'h0);
        cmp("reset carry",    32'(if8.carry), 32'h0);
        cmp("reset overflow", 32'(if8.overflow), 32'h0);
        cmp("reset zero",     32'(if8.zero), 32'h1);
        cmp("reset negative", 32'(if8.negative), 32'h0);

        // First start right after release must be taken on the next rising edge.
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, from_vec(vecs[i]), 1'b1);
            wait_empty(40);
        end

        repeat (3) @(negedge clk);
        #1;
        cmp("hold result", if8.adder_output, 32'hACF1_3568);
        cmp("hold negative", 32'(if8.negative), 32'h1);
        cmp("hold busy", 32'(if8.busy), 32'h0);

        // Back-to-back start in the done cycle, then an ignored start while busy.
        drive(1'b0, 32'h5, 32'h3, from_vec(vecs[0]), 1'b1);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (if8.done) begin
                got = 1'b1;
                break;
            end
        end
        cmp("b2b first_done_seen", 32'(got), 32'h1);
        drive(1'b1, 32'hA, 32'hA, from_vec(vecs[4]), 1'b1);
        cmp("b2b busy_after_restart", 32'(if8.busy), 32'h1);
        cmp("b2b done_after_restart", 32'(if8.done), 32'h0);
        drive(1'b0, 32'h1111_1111, 32'h2222_2222, from_vec(vecs[4]), 1'b0);
        wait_empty(40);
        repeat (2) @(negedge clk);
        #1;
        cmp("ignored start busy", 32'(if8.busy), 32'h0);
        cmp("ignored start result", if8.adder_output, 32'h0);

        // Reset two cycles into an operation aborts it without a done pulse.
        drive(1'b0, 32'd100, 32'd23, from_vec(vecs[0]), 1'b0);
        @(negedge clk);
        cmp("pre-reset partial busy", 32'(if8.busy), 32'h1);
        rst_n = 1'b0;
        #1;
        cmp("abort busy",   32'(if8.busy), 32'h0);
        cmp("abort result", if8.adder_output, 32'h0);
        cmp("abort zero",   32'(if8.zero), 32'h1);
        cmp("abort done",   32'(if8.done), 32'h0);
        repeat (6) @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 32'd100, 32'd23, model(1'b0, 32'd100, 32'd23), 1'b1);
        wait_empty(40);

        // Random operands on all three slice widths.
        wide_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic        o;
            logic [31:0] a;
            logic [31:0] b;
            o = 1'($urandom_range(0, 1));
            a = $urandom;
            b = ((i % 8) == 3) ? a : $urandom;
            if ((i % 16) == 5) a = 32'h8000_0000;
            drive(o, a, b, model(o, a, b), 1'b1);
            wait_empty(80);
        end
        wide_en = 1'b0;

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_addsub_32bit.md
SERIAL_ADDSUB_32BIT -- requirements
Module: serial_addsub_32bit

Interface
REQ-001 Parameter: SLICE_W, 8, width of the slice added per cycle; legal values 1, 2, 4, 8, 16, 32.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: start  input  1  request pulse; sampled only while busy=0.
REQ-005 Port: op  input  1  0 = add, 1 = subtract (input1 - input2); sampled with start.
REQ-006 Port: input1  input  32  operand A; sampled with start.
REQ-007 Port: input2  input  32  operand B; sampled with start.
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  one-cycle pulse when result and flags become valid.
REQ-010 Port: adder_output  output  32  registered result.
REQ-011 Port: carry  output  1  carry-out of bit 31 (for subtract: 1 = no borrow).
REQ-012 Port: overflow  output  1  two's-complement signed overflow.
REQ-013 Port: zero  output  1  adder_output == 0.
REQ-014 Port: negative  output  1  adder_output[31].

Function
REQ-015 States: IDLE, RUN, DONE; N = 32/SLICE_W slices.
REQ-016 IDLE or DONE with start=1 at edge k: latch op, input1, input2 (input2 latched inverted when op=1); set carry-in to op; clear slice counter; go to RUN; busy=1 from edge k.
REQ-017 RUN: at each edge, add the next slice, LSB slice first, using the latched operands and the registered carry; write the slice sum into adder_output; register the slice carry-out; increment the slice counter.
REQ-018 RUN exits after the Nth slice edge (edge k+N): go to DONE; busy=0 and done=1 from that edge, so done rises exactly N cycles after start is sampled (4 cycles for SLICE_W=8).
REQ-019 DONE lasts one cycle; without start it returns to IDLE with done=0.
REQ-020 Start in DONE is accepted as in IDLE (back-to-back): done=0 and busy=1 on the next edge.
REQ-021 start, op and operands are ignored while busy=1; the latched operands do not change mid-operation.
REQ-022 Flags update only at the edge entering DONE:
  - carry = final carry-out;
  - overflow = (A[31]==B'[31]) && (sum[31]!=A[31]), where B' is the effective (possibly inverted) operand;
  - zero and negative derive from the final 32-bit sum.
REQ-023 Result arithmetic is modulo 2^32, with no saturation.
REQ-024 adder_output shows partial sums while busy=1; it is valid only from the done edge.
REQ-025 adder_output and all flags hold their values through IDLE until the next accepted start.
REQ-026 Only the carry chain is sequential; there is no combinational path from inputs to outputs.

Reset
REQ-027 rst_n=0 forces, asynchronously:
  - state IDLE, busy=0, done=0;
  - adder_output=0, carry=0, overflow=0, zero=1, negative=0;
  - slice counter and carry register cleared.
REQ-028 Reset asserted mid-operation aborts it with no done pulse.
REQ-029 The first start is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-030 Add: input1=32'h0000_0005, input2=32'h0000_0003, op=0, start pulse -> done exactly 4 cycles later; adder_output=8; carry=0, overflow=0, zero=0, negative=0.
REQ-031 Carry across all slices: 32'hFFFF_FFFF + 32'h0000_0001, op=0 -> adder_output=0, carry=1, zero=1, overflow=0.
REQ-032 Signed overflow: 32'h7FFF_FFFF + 1, op=0 -> adder_output=32'h8000_0000, overflow=1, negative=1, carry=0. Subtract: 5 - 7, op=1 -> adder_output=32'hFFFF_FFFE, carry=0, negative=1.
REQ-033 Back-to-back and ignore: start again in the done cycle with 10 - 10, op=1 -> second done 4 cycles later with adder_output=0, zero=1, carry=1; a start pulse with new operands while busy=1 is ignored and the result is unchanged.
REQ-034 Reset mid-operation: assert rst_n=0 two cycles after start -> immediately busy=0, adder_output=0, zero=1, no done pulse; the next start after release gives the correct result.
REQ-035 Random: 1000 random operand/op pairs, also run with SLICE_W=1 and 32 -> every result and flag matches a 33-bit reference model; done latency = 32/SLICE_W cycles.
